// File: rtl/des_key_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : des_key_sequencer (with permuted_choice_1 / permuted_choice_2)
// Brief    : Sequential DES key schedule, one subkey per handshake; decrypt
//            order is produced by rotating C/D right. Optional byte parity
//            check when DES_KEY_PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================

module permuted_choice_1 (
  input  logic [63:0] key,
  output logic [55:0] cd
);
  // DES bit n (1 = MSB) lives at key[64-n]
  localparam logic [6*56-1:0] PC1_TBL = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
    6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
    6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
    6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

  for (genvar i = 0; i < 56; i++) begin : g_bit
    localparam int SRC = 64 - int'(PC1_TBL[6*(55-i) +: 6]);
    assign cd[55-i] = key[SRC[5:0]];
  end
endmodule

module permuted_choice_2 (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  localparam logic [6*48-1:0] PC2_TBL = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  for (genvar i = 0; i < 48; i++) begin : g_bit
    localparam int SRC = 56 - int'(PC2_TBL[6*(47-i) +: 6]);
    assign subkey[47-i] = cd[SRC[5:0]];
  end
endmodule

module des_key_sequencer #(
  parameter int PIPE_PC2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  step_q, step_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [55:0] pc1_out;
  logic [55:0] pc2_in;
  logic [47:0] pc2_out;
  logic        accept, take, launch, key_ok;

  function automatic logic [1:0] shift_of(input logic [3:0] idx);
    return (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  permuted_choice_1 u_pc1 (.key(key),   .cd(pc1_out));
  permuted_choice_2 u_pc2 (.cd(pc2_in), .subkey(pc2_out));

  assign accept = (state_q == S_RUN) && subkey_ready;
  // done_q marks the first IDLE cycle, during which start is still ignored
  assign take   = (state_q == S_IDLE) && start && !done_q;
  assign launch = take && key_ok;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) key_ok = key_ok & (^key[8*b +: 8]);
  end

  always_comb begin
    parity_err_d = parity_err_q;
    if (take) parity_err_d = ~key_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          mode_d = decrypt;
          step_d = 4'd0;
          // C16 equals C0, so decrypt starts from the unrotated halves
          if (decrypt) begin
            c_d = pc1_out[55:28];
            d_d = pc1_out[27:0];
          end else begin
            c_d = rotl(pc1_out[55:28], 2'd1);
            d_d = rotl(pc1_out[27:0], 2'd1);
          end
          state_d = (PIPE_PC2 != 0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          if (step_q == 4'd15) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            if (mode_q) begin
              c_d = rotr(c_q, shift_of(4'd15 - step_q));
              d_d = rotr(d_q, shift_of(4'd15 - step_q));
            end else begin
              c_d = rotl(c_q, shift_of(step_q + 4'd1));
              d_d = rotl(d_q, shift_of(step_q + 4'd1));
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  if (PIPE_PC2 != 0) begin : g_pipe_pc2
    logic [47:0] subkey_q, subkey_d;

    // PC2 looks at the next C/D so the registered subkey tracks step_q
    assign pc2_in = {c_d, d_d};

    always_comb begin
      subkey_d = subkey_q;
      if (state_q == S_LOAD || (accept && step_q != 4'd15)) subkey_d = pc2_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) subkey_q <= '0;
      else        subkey_q <= subkey_d;
    end

    assign subkey = subkey_q;
  end else begin : g_comb_pc2
    assign pc2_in = {c_q, d_q};
    assign subkey = pc2_out;
  end

  assign subkey_valid = (state_q == S_RUN);
  assign round        = step_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_des_key_sequencer
// Brief    : Self-checking bench for des_key_sequencer against a key-schedule
//            model; parity scenario enabled with DES_KEY_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_des_key_sequencer;
  localparam int PIPE = 1;
  localparam logic [63:0] T1_KEY = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        parity_err;

  des_key_sequencer #(.PIPE_PC2(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .subkey_ready(subkey_ready), .subkey_valid(subkey_valid), .subkey(subkey),
    .round(round), .busy(busy), .done(done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                    60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                    29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_keys[16];
  logic [47:0] got[16];

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          rdy_pct;
    int          stall_round;
    bit          perturb;
    bit          has_exp;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Textbook schedule: cumulative left shifts, then reverse the list for decrypt
  function automatic void model(input logic [63:0] k, input logic dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks[16];
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shifts[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[r][47-j] = cd[56-pc2_t[j]];
    end
    for (int r = 0; r < 16; r++) exp_keys[r] = dec ? ks[15-r] : ks[r];
  endfunction

  function automatic logic [63:0] odd_par(input logic [63:0] k);
    logic [63:0] r = k;
    for (int b = 0; b < 8; b++) if (!(^r[8*b +: 8])) r[8*b] = ~r[8*b];
    return r;
  endfunction

  task automatic run_seq(input logic [63:0] k, input logic dec, input int rdy_pct,
                         input int stall_round, input bit perturb);
    int idx, lat, cyc, stall;
    bit held;
    logic [47:0] prev;
    logic [3:0] prev_round;
    model(k, dec);
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("parity_clear", parity_err, 0);
    lat = 1;
    while (!subkey_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (PIPE != 0) ? 2 : 1);
    idx = 0; cyc = 0; stall = 0; held = 0; prev = '0; prev_round = '0;
    while (idx < 16 && cyc < 2000) begin
      check("valid", subkey_valid, 1);
      check("round", round, idx);
      check("subkey", subkey, exp_keys[idx]);
      if (held) begin
        check("stall_subkey", subkey, prev);
        check("stall_round", round, prev_round);
      end
      if (perturb && idx == 5) begin
        start = 1'b1; key = ~k; decrypt = ~dec;
      end else start = 1'b0;
      if (idx == stall_round && stall < 10) begin
        subkey_ready = 1'b0;
        stall++;
      end else subkey_ready = ($urandom_range(99) < rdy_pct);
      prev = subkey; prev_round = round; held = !subkey_ready;
      got[idx] = subkey;
      if (subkey_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    check("complete", idx, 16);
    if (rdy_pct == 100 && stall_round < 0) check("no_bubbles", cyc, 16);
    check("done_pulse", done, 1);
    check("valid_drop", subkey_valid, 0);
    check("busy_drop", busy, 0);
    subkey_ready = 1'b0;
    start = perturb;
    @(negedge clk);
    start = 1'b0;
    check("done_once", done, 0);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    vecs[0] = '{T1_KEY, 1'b0, 100, -1, 1'b0, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[1] = '{T1_KEY, 1'b1, 100, -1, 1'b0, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2] = '{T1_KEY, 1'b0, 50,   7, 1'b0, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[3] = '{T1_KEY, 1'b0, 100, -1, 1'b1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    for (int i = 4; i < 8; i++)
      vecs[i] = '{odd_par({$urandom, $urandom}), 1'($urandom_range(1)), 70, -1, 1'b0, 1'b0, '0, '0};

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", subkey_valid, 0);
    check("rst_subkey", subkey, 0);
    check("rst_round", round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_parity", parity_err, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_seq(vecs[v].key, vecs[v].dec, vecs[v].rdy_pct, vecs[v].stall_round, vecs[v].perturb);
      if (vecs[v].has_exp) begin
        check("first_subkey", got[0], vecs[v].first);
        check("last_subkey", got[15], vecs[v].last);
      end
    end

    // Reset mid-run, then a clean restart
    @(negedge clk);
    key = T1_KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(subkey_valid && round == 4'd9) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_round9", round, 9);
    rst_n = 1'b0;
    #1;
    check("arst_valid", subkey_valid, 0);
    check("arst_subkey", subkey, 0);
    check("arst_round", round, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    subkey_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(T1_KEY, 1'b0, 100, -1, 1'b0);
    check("restart_first", got[0], 48'h1B02EFFC7072);

`ifdef DES_KEY_PARITY_CHECK_EN
    @(negedge clk);
    key = 64'h0; decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("parity_set", parity_err, 1);
    repeat (3) @(negedge clk);
    check("parity_no_valid", subkey_valid, 0);
    check("parity_no_busy", busy, 0);
    check("parity_no_done", done, 0);
    check("parity_sticky", parity_err, 1);
    run_seq(T1_KEY, 1'b0, 100, -1, 1'b0);
    check("parity_t1_first", got[0], 48'h1B02EFFC7072);
    check("parity_t1_last", got[15], 48'hCB3D8B0E17F5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
